l2_l1_xbar_reg: RTL and testbench

- Registered return-path crossbar from the L2 stage back to the L1 stage of the symmetric butterfly.
- Applies the inverse of the L1->L2 section permutation, so a flit sent on L2 port a reaches the L1 port that feeds L2 port a in the forward direction.
- Each of the 64 lanes has a 2-entry valid/ready skid buffer. This breaks the long wire path and gives full-throughput backpressure.
- Sits between the L2 node outputs and the L1 node return inputs.

---
 rtl/xbar_pkg.sv | 33 +++
 rtl/xbar_skid2.sv | 78 +++++++
 rtl/l2_l1_xbar_reg.sv | 50 +++++
 tb/tb_l2_l1_xbar_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared definitions for the L1/L2 butterfly crossbars: geometry, payload type,
// skid buffer states and the section-permutation index helpers.
package xbar_pkg;

   localparam int SECTIONS      = 4;
   localparam int NODES         = 4;
   localparam int NODE_PORTS    = 4;
   localparam int XBAR_PORTS    = SECTIONS * NODES * NODE_PORTS;
   localparam int CHANNEL_WIDTH = 18;

   typedef logic [CHANNEL_WIDTH-1:0] ch_t;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_t;

   // Lane a = 16k+4i+j maps to lane 16j+4i+k: the base-4 digits are reversed.
   function automatic int l2_to_l1_idx(input int a);
      return (NODES * SECTIONS) * (a % NODE_PORTS)
           + NODE_PORTS * ((a / NODE_PORTS) % NODES)
           + a / (NODE_PORTS * NODES);
   endfunction

   // Reversing the digits twice is the identity, so the inverse has the same form.
   function automatic int l1_to_l2_idx(input int b);
      return (NODES * SECTIONS) * (b % NODE_PORTS)
           + NODE_PORTS * ((b / NODE_PORTS) % NODES)
           + b / (NODE_PORTS * NODES);
   endfunction

endpackage

// File: rtl/xbar_skid2.sv
// Two-entry valid/ready skid buffer for one crossbar lane. Ready depends only on
// the occupancy register, so the downstream ready never reaches the upstream ready.
module xbar_skid2
   import xbar_pkg::*;
#(
   parameter int CHANNEL_WIDTH = 18
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CHANNEL_WIDTH-1:0] in_ch,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [CHANNEL_WIDTH-1:0] out_ch,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     nonempty
);

   skid_state_t              state_reg, state_next;
   logic [CHANNEL_WIDTH-1:0] head_reg, head_next;
   logic [CHANNEL_WIDTH-1:0] tail_reg, tail_next;
   logic                     push, pop;

   assign in_ready  = (state_reg != SKID_FULL);
   assign out_valid = (state_reg != SKID_EMPTY);
   assign nonempty  = (state_reg != SKID_EMPTY);
   assign out_ch    = head_reg;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= SKID_EMPTY;
         head_reg  <= '0;
         tail_reg  <= '0;
      end else begin
         state_reg <= state_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      head_next  = head_reg;
      tail_next  = tail_reg;
      unique case (state_reg)
         SKID_EMPTY: begin
            if (push) begin
               state_next = SKID_ONE;
               head_next  = in_ch;
            end
         end
         SKID_ONE: begin
            // Simultaneous push and pop keeps one entry: the new flit replaces the head.
            if (push && pop) begin
               head_next = in_ch;
            end else if (push) begin
               state_next = SKID_FULL;
               tail_next  = in_ch;
            end else if (pop) begin
               state_next = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (pop) begin
               state_next = SKID_ONE;
               head_next  = tail_reg;
            end
         end
         default: begin
            state_next = SKID_EMPTY;
         end
      endcase
   end

endmodule

// File: rtl/l2_l1_xbar_reg.sv
// Registered L2->L1 return crossbar: one skid buffer per L2 lane, with its output
// routed to the L1 lane given by the inverse of the L1->L2 section permutation.
module l2_l1_xbar_reg #(
   parameter int PORTS         = 64,
   parameter int CHANNEL_WIDTH = 18,
   parameter int DEPTH         = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [PORTS-1:0][CHANNEL_WIDTH-1:0]  l2_out_ch,
   input  logic [PORTS-1:0]                     l2_out_valid,
   output logic [PORTS-1:0]                     l2_out_ready,
   output logic [PORTS-1:0][CHANNEL_WIDTH-1:0]  l1_in_ch,
   output logic [PORTS-1:0]                     l1_in_valid,
   input  logic [PORTS-1:0]                     l1_in_ready,
   output logic                                 busy
);

   import xbar_pkg::*;

   logic [PORTS-1:0] lane_nonempty;

   if (PORTS != XBAR_PORTS) begin : g_bad_ports
      $error("l2_l1_xbar_reg: PORTS must be 64");
   end
   if (DEPTH != 2) begin : g_bad_depth
      $error("l2_l1_xbar_reg: DEPTH must be 2");
   end

   for (genvar gi = 0; gi < PORTS; gi++) begin : g_lane
      localparam int DST = l2_to_l1_idx(gi);

      xbar_skid2 #(
         .CHANNEL_WIDTH(CHANNEL_WIDTH)
      ) u_skid (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_ch     (l2_out_ch[gi]),
         .in_valid  (l2_out_valid[gi]),
         .in_ready  (l2_out_ready[gi]),
         .out_ch    (l1_in_ch[DST]),
         .out_valid (l1_in_valid[DST]),
         .out_ready (l1_in_ready[DST]),
         .nonempty  (lane_nonempty[gi])
      );
   end

   assign busy = |lane_nonempty;

endmodule

// File: tb/tb_l2_l1_xbar_reg.sv
// Directed and random stimulus for l2_l1_xbar_reg; a negedge monitor scores every
// L1-side handshake against per-lane queues filled from L2-side handshakes.
module tb_l2_l1_xbar_reg;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [63:0][17:0]     l2_out_ch;
   logic [63:0]           l2_out_valid;
   logic [63:0]           l2_out_ready;
   logic [63:0][17:0]     l1_in_ch;
   logic [63:0]           l1_in_valid;
   logic [63:0]           l1_in_ready;
   logic                  busy;

   int total = 0;
   int bad   = 0;

   logic [17:0] exp_q [64][$];
   logic        stalled  [64];
   logic [17:0] held_ch  [64];

   always #5 clk = ~clk;

   l2_l1_xbar_reg #(
      .PORTS(64), .CHANNEL_WIDTH(18), .DEPTH(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .l2_out_ch    (l2_out_ch),
      .l2_out_valid (l2_out_valid),
      .l2_out_ready (l2_out_ready),
      .l1_in_ch     (l1_in_ch),
      .l1_in_valid  (l1_in_valid),
      .l1_in_ready  (l1_in_ready),
      .busy         (busy)
   );

   // Bench-side lane map: swap the outer base-4 digits of the 6-bit lane number.
   function automatic logic [5:0] tb_map(input logic [5:0] a);
      return {a[1:0], a[3:2], a[5:4]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: pops before pushes, so a same-cycle push never satisfies an older pop.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < 64; b++) begin
            exp_q[b].delete();
            stalled[b] = 1'b0;
         end
      end else begin
         for (int b = 0; b < 64; b++) begin
            if (stalled[b]) begin
               chk($sformatf("hold_valid[%0d]", b), 64'(l1_in_valid[b]), 64'd1);
               chk($sformatf("hold_ch[%0d]", b), 64'(l1_in_ch[b]), 64'(held_ch[b]));
            end
            if (l1_in_valid[b] && l1_in_ready[b]) begin
               chk($sformatf("sb_expected[%0d]", b), 64'(exp_q[b].size() != 0), 64'd1);
               if (exp_q[b].size() != 0)
                  chk($sformatf("sb_data[%0d]", b), 64'(l1_in_ch[b]), 64'(exp_q[b].pop_front()));
            end
            stalled[b] = l1_in_valid[b] && !l1_in_ready[b];
            held_ch[b] = l1_in_ch[b];
         end
         for (int a = 0; a < 64; a++)
            if (l2_out_valid[a] && l2_out_ready[a])
               exp_q[tb_map(6'(a))].push_back(l2_out_ch[a]);
      end
   end

   initial begin
      int pending;
      rst_n        = 1'b0;
      l2_out_valid = '0;
      l2_out_ch    = '0;
      l1_in_ready  = '1;
      #1;
      chk("reset_ready", l2_out_ready, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("reset_valid", l1_in_valid, 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_ch0", 64'(l1_in_ch[0]), 64'd0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // Single flit on lane 17: digits (1,0,1) are symmetric, so it lands on L1 lane 17.
      tick();
      l2_out_valid[17] = 1'b1;
      l2_out_ch[17]    = 18'h2ABCD;
      chk("t1_pre_valid", l1_in_valid, 64'd0);
      tick();
      l2_out_valid[17] = 1'b0;
      chk("t1_valid", l1_in_valid, 64'h0000_0000_0002_0000);
      chk("t1_ch", 64'(l1_in_ch[17]), 64'h2ABCD);
      chk("t1_busy", 64'(busy), 64'd1);
      tick();
      chk("t1_drain_valid", l1_in_valid, 64'd0);
      chk("t1_drain_busy", 64'(busy), 64'd0);

      // Full-rate streaming on every lane, payload = lane index + 64*cycle.
      l2_out_valid = '1;
      for (int a = 0; a < 64; a++) l2_out_ch[a] = 18'(a);
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk($sformatf("t2_ready_c%0d", c), l2_out_ready, 64'hFFFF_FFFF_FFFF_FFFF);
         chk($sformatf("t2_valid_c%0d", c), l1_in_valid, 64'hFFFF_FFFF_FFFF_FFFF);
         for (int b = 0; b < 64; b++)
            chk($sformatf("t2_ch_c%0d_b%0d", c, b), 64'(l1_in_ch[b]),
                64'(tb_map(6'(b))) + 64'((c - 1) * 64));
         for (int a = 0; a < 64; a++) l2_out_ch[a] = 18'(a + c * 64);
      end
      l2_out_valid = '0;
      tick();
      chk("t2_drain_busy", 64'(busy), 64'd0);

      // Backpressure: L2 lane 5 feeds L1 lane 20, which is held not ready.
      l1_in_ready[20]  = 1'b0;
      l2_out_valid[5]  = 1'b1;
      l2_out_ch[5]     = 18'd1;
      chk("t3_ready0", 64'(l2_out_ready[5]), 64'd1);
      tick();
      l2_out_ch[5] = 18'd2;
      chk("t3_ready1", 64'(l2_out_ready[5]), 64'd1);
      chk("t3_valid20", 64'(l1_in_valid[20]), 64'd1);
      chk("t3_head1", 64'(l1_in_ch[20]), 64'd1);
      tick();
      l2_out_ch[5] = 18'd3;
      chk("t3_full_ready", 64'(l2_out_ready[5]), 64'd0);
      tick();
      chk("t3_full_ready_hold", 64'(l2_out_ready[5]), 64'd0);
      chk("t3_head_hold", 64'(l1_in_ch[20]), 64'd1);
      l1_in_ready[20] = 1'b1;
      tick();
      chk("t3_head2", 64'(l1_in_ch[20]), 64'd2);
      chk("t3_ready_back", 64'(l2_out_ready[5]), 64'd1);
      tick();
      l2_out_valid[5] = 1'b0;
      chk("t3_head3", 64'(l1_in_ch[20]), 64'd3);
      tick();
      chk("t3_empty", 64'(l1_in_valid[20]), 64'd0);

      // Random valid/ready on all lanes; the monitor checks order, loss, duplication, stability.
      for (int c = 0; c < 10000; c++) begin
         l2_out_valid = {$urandom, $urandom};
         l1_in_ready  = {$urandom, $urandom} | {$urandom, $urandom};
         for (int a = 0; a < 64; a++) l2_out_ch[a] = 18'($urandom);
         tick();
      end
      l2_out_valid = '0;
      l1_in_ready  = '1;
      repeat (4) tick();
      chk("t4_busy", 64'(busy), 64'd0);
      pending = 0;
      for (int b = 0; b < 64; b++) pending += exp_q[b].size();
      chk("t4_no_loss", 64'(pending), 64'd0);

      // Fill every lane to two entries, then assert reset between clock edges.
      l1_in_ready  = '0;
      l2_out_valid = '1;
      for (int a = 0; a < 64; a++) l2_out_ch[a] = 18'(a + 1);
      repeat (3) tick();
      chk("t5_full", l2_out_ready, 64'd0);
      chk("t5_busy_pre", 64'(busy), 64'd1);
      l2_out_valid = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_valid", l1_in_valid, 64'd0);
      chk("t5_async_busy", 64'(busy), 64'd0);
      chk("t5_async_ready", l2_out_ready, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t5_async_ch", 64'(l1_in_ch[0]), 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      l1_in_ready = '1;
      tick();
      l2_out_valid[0] = 1'b1;
      l2_out_ch[0]    = 18'h00001;
      tick();
      l2_out_valid[0] = 1'b0;
      chk("t5_post_valid", l1_in_valid, 64'd1);
      chk("t5_post_ch", 64'(l1_in_ch[0]), 64'd1);
      tick();
      chk("t5_post_empty", l1_in_valid, 64'd0);
      @(negedge clk);
      pending = 0;
      for (int b = 0; b < 64; b++) pending += exp_q[b].size();
      chk("end_no_loss", 64'(pending), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
